// File: rtl/multi_cycle_control_if.sv
// Control/status bundle between the multi-cycle controller and its datapath.
// Signal names keep the controller's port naming so both sides read the same.
interface multi_cycle_control_if #(
  parameter int unsigned CNT_W = 16
);
  logic [3:0]       input_opcode;
  logic [3:0]       input_funct;
  logic             input_Zero;
  logic             input_mem_ready;
  logic [1:0]       output_ALUSrcA;
  logic [1:0]       output_ALUSrcB;
  logic [3:0]       output_ALUOp;
  logic             output_PCSrc;
  logic             output_PCWrite;
  logic             output_IRWrite;
  logic             output_IorD;
  logic             output_MemRead;
  logic             output_MemWrite;
  logic             output_RegWrite;
  logic             output_RegDst;
  logic             output_MemtoReg;
  logic             output_halted;
  logic             output_illegal;
  logic             output_bus_error;
  logic [3:0]       output_state;
  logic [CNT_W-1:0] output_instr_count;

  // Controller side.
  modport master (
    input  input_opcode, input_funct, input_Zero, input_mem_ready,
    output output_ALUSrcA, output_ALUSrcB, output_ALUOp, output_PCSrc,
           output_PCWrite, output_IRWrite, output_IorD, output_MemRead,
           output_MemWrite, output_RegWrite, output_RegDst, output_MemtoReg,
           output_halted, output_illegal, output_bus_error, output_state,
           output_instr_count
  );

  // Datapath side.
  modport slave (
    output input_opcode, input_funct, input_Zero, input_mem_ready,
    input  output_ALUSrcA, output_ALUSrcB, output_ALUOp, output_PCSrc,
           output_PCWrite, output_IRWrite, output_IorD, output_MemRead,
           output_MemWrite, output_RegWrite, output_RegDst, output_MemtoReg,
           output_halted, output_illegal, output_bus_error, output_state,
           output_instr_count
  );
endinterface

// File: rtl/multi_cycle_control.sv
// Moore control FSM for the 16-bit multi-cycle datapath: per-phase mux selects,
// ALU op and write strobes, memory-ready wait with timeout, sticky halt flags.
module multi_cycle_control #(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned CNT_W       = 16
) (
  input logic                  clk,
  input logic                  reset_n,
  multi_cycle_control_if.master bus
);

  localparam int unsigned WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

  localparam logic [3:0] OP_R    = 4'h0;
  localparam logic [3:0] OP_ADDI = 4'h1;
  localparam logic [3:0] OP_LW   = 4'h2;
  localparam logic [3:0] OP_SW   = 4'h3;
  localparam logic [3:0] OP_BEQ  = 4'h4;
  localparam logic [3:0] OP_BNE  = 4'h5;
  localparam logic [3:0] OP_J    = 4'h6;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_EXEC_R    = 4'd2,
    S_EXEC_I    = 4'd3,
    S_WB_ALU    = 4'd4,
    S_MEM_ADDR  = 4'd5,
    S_MEM_READ  = 4'd6,
    S_WB_MEM    = 4'd7,
    S_MEM_WRITE = 4'd8,
    S_BRANCH    = 4'd9,
    S_JUMP      = 4'd10,
    S_HALT      = 4'd11
  } state_e;

  state_e             state_q, state_d;
  logic [3:0]         op_q, op_d;
  logic [3:0]         funct_q, funct_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               halted_q, halted_d;
  logic               illegal_q, illegal_d;
  logic               bus_error_q, bus_error_d;

  logic mem_stall;
  logic timeout;

  assign mem_stall = (state_q inside {S_FETCH, S_MEM_READ, S_MEM_WRITE}) && !bus.input_mem_ready;
  // The access that would be the MEM_TIMEOUT-th wait cycle ends the instruction.
  assign timeout   = (MEM_TIMEOUT != 0) && mem_stall &&
                     ((32'(wait_q) + 32'd1) == MEM_TIMEOUT);

  // NOTE: every signal gets a default before the case, so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    funct_d     = funct_q;
    illegal_d   = illegal_q;
    bus_error_d = bus_error_q;
    count_d     = count_q;
    wait_d      = (mem_stall && !timeout) ? wait_q + 1'b1 : '0;

    case (state_q)
      S_FETCH:     if (bus.input_mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        op_d    = bus.input_opcode;
        funct_d = bus.input_funct;
        case (bus.input_opcode)
          OP_R:           state_d = S_EXEC_R;
          OP_ADDI:        state_d = S_EXEC_I;
          OP_LW, OP_SW:   state_d = S_MEM_ADDR;
          OP_BEQ, OP_BNE: state_d = S_BRANCH;
          OP_J:           state_d = S_JUMP;
          OP_HALT:        state_d = S_HALT;
          default: begin
            illegal_d = 1'b1;
            state_d   = S_HALT;
          end
        endcase
      end
      S_EXEC_R, S_EXEC_I:       state_d = S_WB_ALU;
      S_MEM_ADDR:               state_d = (op_q == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
      S_MEM_READ:               if (bus.input_mem_ready) state_d = S_WB_MEM;
      S_MEM_WRITE:              if (bus.input_mem_ready) state_d = S_FETCH;
      S_WB_ALU, S_WB_MEM,
      S_BRANCH, S_JUMP:         state_d = S_FETCH;
      S_HALT:                   state_d = S_HALT;
      default:                  state_d = S_FETCH;
    endcase

    if (timeout) begin
      bus_error_d = 1'b1;
      state_d     = S_HALT;
    end

    halted_d = halted_q | (state_d == S_HALT);
    if (state_d == S_FETCH && state_q != S_FETCH) count_d = count_q + 1'b1;
  end

  // NOTE: reset is sampled inside the clocked block only, and all state uses <=.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= S_FETCH;
      op_q        <= '0;
      funct_q     <= '0;
      wait_q      <= '0;
      count_q     <= '0;
      halted_q    <= 1'b0;
      illegal_q   <= 1'b0;
      bus_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      funct_q     <= funct_d;
      wait_q      <= wait_d;
      count_q     <= count_d;
      halted_q    <= halted_d;
      illegal_q   <= illegal_d;
      bus_error_q <= bus_error_d;
    end
  end

  logic [1:0] src_a, src_b;
  logic [3:0] alu_op;
  logic       pc_src, pc_write, ir_write, i_or_d, mem_read, mem_write;
  logic       reg_write, reg_dst, mem_to_reg;

  always_comb begin
    src_a      = 2'd0;
    src_b      = 2'd0;
    alu_op     = ALU_ADD;
    pc_src     = 1'b0;
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    i_or_d     = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;

    case (state_q)
      S_FETCH: begin
        mem_read = 1'b1;
        src_b    = 2'd1;
        ir_write = bus.input_mem_ready;
        pc_write = bus.input_mem_ready;
      end
      S_DECODE:   src_b = 2'd2;
      S_EXEC_R: begin
        src_a  = 2'd2;
        alu_op = funct_q;
      end
      S_EXEC_I, S_MEM_ADDR: begin
        src_a = 2'd2;
        src_b = 2'd2;
      end
      S_WB_ALU: begin
        reg_write = 1'b1;
        reg_dst   = (op_q == OP_ADDI);
      end
      S_MEM_READ: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      S_WB_MEM: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        reg_dst    = 1'b1;
      end
      S_MEM_WRITE: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
      end
      S_BRANCH: begin
        src_a    = 2'd2;
        alu_op   = ALU_SUB;
        pc_src   = 1'b1;
        pc_write = (op_q == OP_BEQ) ? bus.input_Zero : !bus.input_Zero;
      end
      S_JUMP: begin
        src_a    = 2'd3;
        src_b    = 2'd3;
        pc_write = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.output_ALUSrcA     = src_a;
  assign bus.output_ALUSrcB     = src_b;
  assign bus.output_ALUOp       = alu_op;
  assign bus.output_PCSrc       = pc_src;
  assign bus.output_IorD        = i_or_d;
  assign bus.output_RegDst      = reg_dst;
  assign bus.output_MemtoReg    = mem_to_reg;
  // Strobes are forced low during reset so an aborted instruction writes nothing.
  assign bus.output_PCWrite     = pc_write  & reset_n;
  assign bus.output_IRWrite     = ir_write  & reset_n;
  assign bus.output_MemRead     = mem_read  & reset_n;
  assign bus.output_MemWrite    = mem_write & reset_n;
  assign bus.output_RegWrite    = reg_write & reset_n;
  assign bus.output_halted      = halted_q;
  assign bus.output_illegal     = illegal_q;
  assign bus.output_bus_error   = bus_error_q;
  assign bus.output_state       = state_q;
  assign bus.output_instr_count = count_q;

endmodule

// File: tb/tb_multi_cycle_control.sv
// Bench for multi_cycle_control: instruction-level reference model checked every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_multi_cycle_control;

  localparam int unsigned TO = 4;
  localparam int unsigned CW = 4;

  localparam int P_FETCH = 0, P_DECODE = 1, P_EXEC_R = 2, P_EXEC_I = 3, P_WB_ALU = 4,
                 P_MEM_ADDR = 5, P_MEM_READ = 6, P_WB_MEM = 7, P_MEM_WRITE = 8,
                 P_BRANCH = 9, P_JUMP = 10, P_HALT = 11;

  logic clk = 1'b0;
  logic reset_n;

  multi_cycle_control_if #(.CNT_W(CW)) bus ();

  multi_cycle_control #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: which phase the current instruction is in and what remains.
  int         m_phase;
  int         m_path[$];
  int         m_wait;
  int         m_count;
  bit         m_illegal, m_buserr, m_valid = 1'b0;
  logic [3:0] m_op, m_fn;

  function automatic logic [16:0] exp_ctrl(input int ph, input logic [3:0] op,
                                           input logic [3:0] fn, input logic z,
                                           input logic rdy);
    logic [1:0] a = 0, b = 0;
    logic [3:0] alu = 4'b0000;
    logic pcsrc = 0, pcw = 0, irw = 0, iord = 0, mr = 0, mw = 0, rw = 0, rd = 0, m2r = 0;
    case (ph)
      P_FETCH:     begin mr = 1; b = 1; irw = rdy; pcw = rdy; end
      P_DECODE:    b = 2;
      P_EXEC_R:    begin a = 2; alu = fn; end
      P_EXEC_I:    begin a = 2; b = 2; end
      P_WB_ALU:    begin rw = 1; rd = (op == 4'h1); end
      P_MEM_ADDR:  begin a = 2; b = 2; end
      P_MEM_READ:  begin mr = 1; iord = 1; end
      P_WB_MEM:    begin rw = 1; m2r = 1; rd = 1; end
      P_MEM_WRITE: begin mw = 1; iord = 1; end
      P_BRANCH:    begin a = 2; alu = 4'b0001; pcsrc = 1; pcw = (op == 4'h4) ? z : !z; end
      P_JUMP:      begin a = 3; b = 3; pcw = 1; end
      default: ;
    endcase
    return {a, b, alu, pcsrc, pcw, irw, iord, mr, mw, rw, rd, m2r};
  endfunction

  task automatic next_phase();
    m_wait = 0;
    if (m_path.size() == 0) begin
      m_phase = P_FETCH;
      m_count = (m_count + 1) % (1 << CW);
    end else begin
      m_phase = m_path.pop_front();
    end
  endtask

  task automatic advance();
    case (m_phase)
      P_FETCH, P_MEM_READ, P_MEM_WRITE:
        if (bus.input_mem_ready) begin
          if (m_phase == P_FETCH) begin
            m_wait  = 0;
            m_phase = P_DECODE;
          end else begin
            next_phase();
          end
        end else begin
          m_wait++;
          if (TO != 0 && m_wait == int'(TO)) begin
            m_buserr = 1'b1;
            m_phase  = P_HALT;
            m_wait   = 0;
          end
        end
      P_DECODE: begin
        m_op = bus.input_opcode;
        m_fn = bus.input_funct;
        m_path.delete();
        case (m_op)
          4'h0: begin m_path.push_back(P_EXEC_R); m_path.push_back(P_WB_ALU); end
          4'h1: begin m_path.push_back(P_EXEC_I); m_path.push_back(P_WB_ALU); end
          4'h2: begin m_path.push_back(P_MEM_ADDR); m_path.push_back(P_MEM_READ);
                      m_path.push_back(P_WB_MEM); end
          4'h3: begin m_path.push_back(P_MEM_ADDR); m_path.push_back(P_MEM_WRITE); end
          4'h4, 4'h5: m_path.push_back(P_BRANCH);
          4'h6: m_path.push_back(P_JUMP);
          4'hF: ;
          default: m_illegal = 1'b1;
        endcase
        if (m_path.size() == 0) m_phase = P_HALT;
        else m_phase = m_path.pop_front();
      end
      P_HALT: ;
      default: next_phase();
    endcase
  endtask

  logic [16:0] act_ctrl;
  assign act_ctrl = {bus.output_ALUSrcA, bus.output_ALUSrcB, bus.output_ALUOp,
                     bus.output_PCSrc, bus.output_PCWrite, bus.output_IRWrite,
                     bus.output_IorD, bus.output_MemRead, bus.output_MemWrite,
                     bus.output_RegWrite, bus.output_RegDst, bus.output_MemtoReg};

  // Compare process: inputs change on the falling edge, outputs are judged 2 ns later.
  always @(negedge clk) begin
    #2;
    if (!reset_n) begin
      check("rst_strobes", {27'd0, bus.output_PCWrite, bus.output_IRWrite,
            bus.output_MemRead, bus.output_MemWrite, bus.output_RegWrite}, 32'd0);
      m_phase = P_FETCH; m_path.delete(); m_wait = 0; m_count = 0;
      m_illegal = 1'b0; m_buserr = 1'b0; m_valid = 1'b1;
    end else if (m_valid) begin
      check("ctrl", 32'(act_ctrl),
            32'(exp_ctrl(m_phase, m_op, m_fn, bus.input_Zero, bus.input_mem_ready)));
      check("state", 32'(bus.output_state), 32'(m_phase));
      check("flags", {29'd0, bus.output_halted, bus.output_illegal, bus.output_bus_error},
            {29'd0, m_phase == P_HALT, m_illegal, m_buserr});
      check("count", 32'(bus.output_instr_count), 32'(m_count));
      advance();
    end
  end

  task automatic cycle(input logic [3:0] op, input logic [3:0] fn, input logic z,
                       input logic rdy, input logic rst_n);
    @(negedge clk);
    bus.input_opcode    = op;
    bus.input_funct     = fn;
    bus.input_Zero      = z;
    bus.input_mem_ready = rdy;
    reset_n             = rst_n;
    #3;
  endtask

  initial begin
    int hc;
    reset_n             = 1'b0;
    bus.input_opcode    = '0;
    bus.input_funct     = '0;
    bus.input_Zero      = 1'b0;
    bus.input_mem_ready = 1'b0;

    // Reset, then R-type with funct 0010.
    cycle(4'h0, 4'h0, 0, 1, 0);
    cycle(4'h0, 4'h2, 0, 1, 1);
    check("lit_reset_state", 32'(bus.output_state), 32'd0);
    check("lit_reset_count", 32'(bus.output_instr_count), 32'd0);
    check("lit_reset_flags", {29'd0, bus.output_halted, bus.output_illegal,
                              bus.output_bus_error}, 32'd0);
    cycle(4'h0, 4'h2, 0, 1, 1);
    cycle(4'h7, 4'h9, 0, 1, 1);
    check("lit_r_aluop", 32'(bus.output_ALUOp), 32'h2);
    check("lit_r_state", 32'(bus.output_state), 32'd2);
    cycle(4'h7, 4'h9, 0, 1, 1);
    check("lit_r_regwrite", {30'd0, bus.output_RegWrite, bus.output_RegDst}, 32'b10);
    cycle(4'h0, 4'h0, 0, 1, 1);
    check("lit_r_count", 32'(bus.output_instr_count), 32'd1);

    // LW with three not-ready cycles in MEM_READ.
    cycle(4'h2, 4'h0, 0, 1, 1);
    cycle(4'h2, 4'h0, 0, 1, 1);
    check("lit_lw_memaddr", 32'(bus.output_state), 32'd5);
    for (int i = 0; i < 4; i++) begin
      cycle(4'h2, 4'h0, 0, i == 3, 1);
      check("lit_lw_memread", {29'd0, bus.output_state == 4'd6, bus.output_MemRead,
                               bus.output_IorD}, 32'b111);
    end
    cycle(4'h2, 4'h0, 0, 1, 1);
    check("lit_lw_wbmem", {29'd0, bus.output_MemtoReg, bus.output_RegDst,
                           bus.output_RegWrite}, 32'b111);
    cycle(4'h0, 4'h0, 0, 1, 1);
    check("lit_lw_count", 32'(bus.output_instr_count), 32'd2);

    // BEQ taken, BEQ not taken, BNE taken.
    cycle(4'h4, 4'h0, 0, 1, 1);
    cycle(4'h4, 4'h0, 1, 1, 1);
    check("lit_beq_taken", {30'd0, bus.output_PCWrite, bus.output_PCSrc}, 32'b11);
    cycle(4'h0, 4'h0, 0, 1, 1);
    cycle(4'h4, 4'h0, 0, 1, 1);
    cycle(4'h4, 4'h0, 0, 1, 1);
    check("lit_beq_not", 32'(bus.output_PCWrite), 32'd0);
    cycle(4'h0, 4'h0, 0, 1, 1);
    cycle(4'h5, 4'h0, 0, 1, 1);
    cycle(4'h5, 4'h0, 0, 1, 1);
    check("lit_bne_taken", 32'(bus.output_PCWrite), 32'd1);
    cycle(4'h0, 4'h0, 0, 1, 1);
    check("lit_branch_count", 32'(bus.output_instr_count), 32'd5);

    // Illegal opcode 1010: halted for 20 cycles, then reset.
    cycle(4'hA, 4'h0, 0, 1, 1);
    for (int i = 0; i < 20; i++) cycle(4'($urandom), 4'($urandom), 1'($urandom), 1, 1);
    check("lit_illegal_halt", {27'd0, bus.output_state, bus.output_illegal}, {27'd0, 4'd11, 1'b1});
    check("lit_illegal_strobes", {27'd0, bus.output_PCWrite, bus.output_IRWrite,
          bus.output_MemRead, bus.output_MemWrite, bus.output_RegWrite}, 32'd0);
    cycle(4'h0, 4'h0, 0, 1, 0);
    cycle(4'h0, 4'h0, 0, 1, 1);
    check("lit_after_reset", {26'd0, bus.output_state, bus.output_illegal, bus.output_halted},
          32'd0);

    // SW with memory stuck: bus error after four wait cycles.
    cycle(4'h3, 4'h0, 0, 1, 1);
    cycle(4'h3, 4'h0, 0, 1, 1);
    for (int i = 0; i < 4; i++) begin
      cycle(4'h3, 4'h0, 0, 0, 1);
      check("lit_sw_wait", {30'd0, bus.output_MemWrite, bus.output_RegWrite}, 32'b10);
    end
    cycle(4'h3, 4'h0, 0, 0, 1);
    check("lit_sw_buserr", {27'd0, bus.output_state, bus.output_bus_error}, {27'd0, 4'd11, 1'b1});

    // Reset landing on a ready MEM_WRITE cycle suppresses the write.
    cycle(4'h0, 4'h0, 0, 1, 0);
    cycle(4'h3, 4'h0, 0, 1, 1);
    cycle(4'h3, 4'h0, 0, 1, 1);
    cycle(4'h3, 4'h0, 0, 1, 1);
    cycle(4'h3, 4'h0, 0, 1, 0);
    check("lit_rst_memwrite", 32'(bus.output_MemWrite), 32'd0);
    cycle(4'h0, 4'h0, 0, 0, 1);
    check("lit_rst_abort", {28'd0, bus.output_state} | 32'(bus.output_instr_count), 32'd0);

    // Random traffic; reset occasionally and whenever the model has been halted a while.
    hc = 0;
    for (int i = 0; i < 4000; i++) begin
      logic [3:0] op;
      logic       rst_n;
      if ($urandom_range(0, 9) == 0) op = 4'($urandom_range(0, 15));
      else op = 4'($urandom_range(0, 6));
      hc    = (m_phase == P_HALT) ? hc + 1 : 0;
      rst_n = !(hc > 3 || $urandom_range(0, 299) == 0);
      cycle(op, 4'($urandom), 1'($urandom), $urandom_range(0, 9) < 7, rst_n);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multi_cycle_control.md
Name: multi_cycle_control

Overview:
- Moore-style control FSM that sequences the 16-bit multi-cycle calculation datapath: A/B/ALUOut registers, ALUSrcA/ALUSrcB/PCSrc muxes and the ALU.
- Drives mux selects, ALU op and write strobes (PC, IR, register file, memory) per instruction phase.
- Waits on a memory ready handshake and halts on HALT, illegal opcode or memory timeout.
- Sits beside the datapath at top level and consumes the IR opcode/funct fields and ALU flags.

Parameters:
- MEM_TIMEOUT, 255: max consecutive wait cycles in a memory state before bus error; 0 disables the timeout.
- CNT_W, 16: width of the retired-instruction counter.

Ports:
- clk  input  1  system clock, rising edge
- reset_n  input  1  synchronous, active-low reset
- input_opcode  input  4  IR[15:12]
- input_funct  input  4  IR[3:0]; ALU op for R-type
- input_Zero  input  1  ALU zero flag, combinational
- input_mem_ready  input  1  memory completes the current access this cycle
- output_ALUSrcA  output  2  0=PC, 1=const 2, 2=A reg, 3=imm
- output_ALUSrcB  output  2  0=B reg, 1=const 2, 2=imm, 3=zero
- output_ALUOp  output  4  ADD=0000, SUB=0001, else funct passthrough
- output_PCSrc  output  1  0=ALU result, 1=ALUOut reg
- output_PCWrite  output  1  PC load strobe
- output_IRWrite  output  1  IR load strobe
- output_IorD  output  1  memory address source: 0=PC, 1=ALUOut
- output_MemRead  output  1  memory read request
- output_MemWrite  output  1  memory write request
- output_RegWrite  output  1  register file write strobe
- output_RegDst  output  1  0=rd, 1=rt
- output_MemtoReg  output  1  writeback source: 0=ALUOut, 1=MDR
- output_halted  output  1  sticky; set in HALT
- output_illegal  output  1  sticky illegal-opcode flag
- output_bus_error  output  1  sticky memory-timeout flag
- output_state  output  4  current state encoding, for debug
- output_instr_count  output  CNT_W  retired instructions, wraps modulo 2^CNT_W

Behaviour:
- Reset: when reset_n=0 at a clock edge, state<=FETCH; flags, counter and wait counter <=0.
- Reset: all strobes are 0 in any cycle where reset_n=0.
- Reset mid-instruction aborts the instruction with no partial writes after that edge.
- Outputs decode from state only, except FETCH/memory strobes gated by input_mem_ready and BRANCH PCWrite gated by input_Zero.
- Default every cycle: all strobes 0, ALUSrcA=0, ALUSrcB=0, ALUOp=ADD, PCSrc=0, IorD=0, RegDst=0, MemtoReg=0.
- FETCH(0):
  - MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=1, ADD, PCSrc=0.
  - If mem_ready: IRWrite=1, PCWrite=1, ->DECODE.
  - Else: hold in FETCH with both strobes 0.
- DECODE(1):
  - ALUSrcA=0, ALUSrcB=2, ADD (branch target into ALUOut).
  - Latch opcode/funct internally.
  - Next state: 0000->EXEC_R, 0001->EXEC_I, 0010/0011->MEM_ADDR, 0100/0101->BRANCH, 0110->JUMP, 1111->HALT.
  - Any other opcode: set illegal, ->HALT.
- EXEC_R(2): ALUSrcA=2, ALUSrcB=0, ALUOp=latched funct, ->WB_ALU.
- EXEC_I(3): ALUSrcA=2, ALUSrcB=2, ADD, ->WB_ALU.
- WB_ALU(4): RegWrite=1, MemtoReg=0, RegDst=0 for R-type and 1 for ADDI, ->FETCH.
- MEM_ADDR(5): ALUSrcA=2, ALUSrcB=2, ADD; LW->MEM_READ, SW->MEM_WRITE.
- MEM_READ(6): MemRead=1, IorD=1; hold until mem_ready, then ->WB_MEM.
- WB_MEM(7): RegWrite=1, MemtoReg=1, RegDst=1, ->FETCH.
- MEM_WRITE(8): MemWrite=1, IorD=1; hold until mem_ready, then ->FETCH.
- BRANCH(9):
  - ALUSrcA=2, ALUSrcB=0, SUB, PCSrc=1.
  - PCWrite = Zero for BEQ, ~Zero for BNE, same cycle.
  - ->FETCH.
- JUMP(10): ALUSrcA=3, ALUSrcB=3, ADD, PCSrc=0, PCWrite=1, ->FETCH.
- HALT(11): halted=1, all strobes 0; exit only via reset.
- Wait counter:
  - Increments each cycle spent in FETCH/MEM_READ/MEM_WRITE with mem_ready=0.
  - Clears on any state change.
  - When it reaches MEM_TIMEOUT (nonzero) with mem_ready still 0: bus_error<=1, ->HALT.
  - mem_ready=1 in the timeout cycle wins: access completes, no error.
- instr_count increments on every transition into FETCH from a non-FETCH state, excluding reset.
  - HALT and illegal opcodes are not counted.

Test Plan:
- Reset, mem_ready=1, R-type funct=0010 -> states 0,1,2,4,0; ALUOp=0010 in EXEC_R; RegWrite=1 only in WB_ALU; instr_count=1.
- LW with mem_ready low 3 cycles in MEM_READ -> MemRead/IorD=1 held 4 cycles; WB_MEM has MemtoReg=1, RegDst=1; FETCH in cycle 9; count=1.
- BEQ with Zero=1 -> PCWrite=1, PCSrc=1 in BRANCH; BEQ with Zero=0 -> PCWrite=0; BNE with Zero=0 -> PCWrite=1.
- Opcode 1010 -> illegal=1, halted=1, state=11 held 20 cycles with zero strobes; reset_n=0 one cycle -> state 0, flags 0.
- MEM_TIMEOUT=4, SW with mem_ready stuck 0 -> bus_error=1 and HALT after 4 wait cycles; MemWrite never asserted with RegWrite.
- reset_n=0 during MEM_WRITE with mem_ready=1 -> MemWrite=0 that cycle, next state FETCH, count=0.
